// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: widths, register map, FSM states.
// Optional timer on the top line is enabled by defining IRQC_TIMER_EN.
package irq_ctrl_pkg;

  // CPU-side irq bus width; the controller's line count must match it
  localparam int unsigned CPU_IRQ_CH = 8;
  localparam int unsigned IRQ_CH_DEF = CPU_IRQ_CH;
  localparam int unsigned IRQ_MSB    = CPU_IRQ_CH - 1;
  localparam int unsigned IRQ_LSB    = 0;

  localparam int unsigned IRQ_ID_W = 3;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned TIMER_W  = 32;

  // Word offsets on the register bus
  localparam logic [ADDR_W-1:0] ADDR_PEND     = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_EN       = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_MODE     = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_ACTIVE   = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_EOI      = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_TCOUNT   = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_TCOMPARE = 3'd6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } irq_state_e;

endpackage

// File: rtl/irq_ctrl_sync.sv
// Multi-flop synchroniser for the external request lines, plus rising-edge detect.
module irq_sync
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH       = CPU_IRQ_CH,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] sync_q,
  output logic [WIDTH-1:0] rise_c
);

  logic [WIDTH-1:0] stage [SYNC_STAGES];
  logic [WIDTH-1:0] prev;

  // Shift chain; prev holds the last synchronised value for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) stage[s] <= '0;
      prev <= '0;
    end else begin
      stage[0] <= d;
      for (int s = 1; s < SYNC_STAGES; s++) stage[s] <= stage[s-1];
      prev <= stage[SYNC_STAGES-1];
    end
  end

  assign sync_q = stage[SYNC_STAGES-1];
  assign rise_c = sync_q & ~prev;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: sync, pending latch, lowest-index priority, one-hot irq held until EOI.
// Define IRQC_TIMER_EN to turn the top line into a compare-match timer interrupt.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned IRQ_CH      = IRQ_CH_DEF,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IRQ_CH-1:0]   src_irq,
  input  logic                bus_req,
  input  logic                bus_rw,
  input  logic [ADDR_W-1:0]   bus_addr,
  input  logic [DATA_W-1:0]   bus_wr_data,
  output logic [DATA_W-1:0]   bus_rd_data,
  output logic                bus_rdy,
  output logic [IRQ_CH-1:0]   irq,
  output logic [IRQ_ID_W-1:0] irq_id
);

  logic [IRQ_CH-1:0]   sync_q;
  logic [IRQ_CH-1:0]   rise_c;
  logic [IRQ_CH-1:0]   pend;
  logic [IRQ_CH-1:0]   pend_d;
  logic [IRQ_CH-1:0]   en;
  logic [IRQ_CH-1:0]   mode;
  logic [IRQ_CH-1:0]   cand;
  logic [IRQ_CH-1:0]   w1c;
  logic [IRQ_ID_W-1:0] winner;
  logic [DATA_W-1:0]   rd_mux;
  logic                wr;
  logic                rd;
  logic                eoi_wr;
  logic                unused_bits;
  irq_state_e          state;

  irq_sync #(
    .WIDTH       (IRQ_CH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .d      (src_irq),
    .sync_q (sync_q),
    .rise_c (rise_c)
  );

  assign wr     = bus_req & bus_rw;
  assign rd     = bus_req & ~bus_rw;
  assign eoi_wr = wr && (bus_addr == ADDR_EOI);
  assign w1c    = (wr && (bus_addr == ADDR_PEND)) ? bus_wr_data[IRQ_CH-1:0] : '0;
  assign cand   = pend & en;

`ifdef IRQC_TIMER_EN
  logic [TIMER_W-1:0] tcount;
  logic [TIMER_W-1:0] tcompare;
  logic               timer_hit;

  assign timer_hit = (tcompare != '0) && (tcount == tcompare);

  // Free-running counter; a bus write to TCOUNT overrides the increment
  always_ff @(posedge clk) begin
    if (reset) begin
      tcount   <= '0;
      tcompare <= '0;
    end else begin
      if (wr && (bus_addr == ADDR_TCOUNT)) tcount <= TIMER_W'(bus_wr_data);
      else                                 tcount <= tcount + TIMER_W'(1);
      if (wr && (bus_addr == ADDR_TCOMPARE)) tcompare <= TIMER_W'(bus_wr_data);
    end
  end

  assign unused_bits = &{1'b0, sync_q[IRQ_CH-1], rise_c[IRQ_CH-1]};
`else
  assign unused_bits = &{1'b0, bus_wr_data[DATA_W-1:IRQ_CH]};
`endif

  // Next pending: level lines follow the source, edge lines latch rises with set beating clear
  always_comb begin
    pend_d = pend;
    for (int i = 0; i < IRQ_CH; i++) begin
      if (mode[i]) pend_d[i] = rise_c[i] | (pend[i] & ~w1c[i]);
      else         pend_d[i] = sync_q[i];
    end
`ifdef IRQC_TIMER_EN
    pend_d[IRQ_CH-1] = timer_hit | (pend[IRQ_CH-1] & ~w1c[IRQ_CH-1]);
`endif
  end

  // Lowest-index enabled pending line wins
  always_comb begin
    winner = '0;
    for (int i = IRQ_CH - 1; i >= 0; i--) begin
      if (cand[i]) winner = IRQ_ID_W'(i);
    end
  end

  // Register read mux; unmapped offsets and unused bits read zero
  always_comb begin
    rd_mux = '0;
    case (bus_addr)
      ADDR_PEND:     rd_mux = DATA_W'(pend);
      ADDR_EN:       rd_mux = DATA_W'(en);
      ADDR_MODE:     rd_mux = DATA_W'(mode);
      ADDR_ACTIVE:   rd_mux = DATA_W'({state != ST_IDLE, irq_id});
`ifdef IRQC_TIMER_EN
      ADDR_TCOUNT:   rd_mux = DATA_W'(tcount);
      ADDR_TCOMPARE: rd_mux = DATA_W'(tcompare);
`endif
      default:       rd_mux = '0;
    endcase
  end

  // Register file and bus response
  always_ff @(posedge clk) begin
    if (reset) begin
      pend        <= '0;
      en          <= '0;
      mode        <= '0;
      bus_rdy     <= 1'b0;
      bus_rd_data <= '0;
    end else begin
      pend        <= pend_d;
      bus_rdy     <= bus_req;
      bus_rd_data <= rd ? rd_mux : '0;
      if (wr && (bus_addr == ADDR_EN))   en   <= bus_wr_data[IRQ_CH-1:0];
      if (wr && (bus_addr == ADDR_MODE)) mode <= bus_wr_data[IRQ_CH-1:0];
    end
  end

  // Request FSM: grab the winner in IDLE, hold it unchanged until EOI
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      irq    <= '0;
      irq_id <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cand != '0) begin
            state  <= ST_REQ;
            irq_id <= winner;
            irq    <= IRQ_CH'(1) << winner;
          end
        end
        ST_REQ: begin
          if (eoi_wr) begin
            state <= ST_IDLE;
            irq   <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          irq   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl; timer steps run only when IRQC_TIMER_EN is defined.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  src_irq;
  logic        bus_req;
  logic        bus_rw;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wr_data;
  logic [31:0] bus_rd_data;
  logic        bus_rdy;
  logic [7:0]  irq;
  logic [2:0]  irq_id;

  int total = 0;
  int bad   = 0;
  logic [31:0] rdv;

  irq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .src_irq     (src_irq),
    .bus_req     (bus_req),
    .bus_rw      (bus_rw),
    .bus_addr    (bus_addr),
    .bus_wr_data (bus_wr_data),
    .bus_rd_data (bus_rd_data),
    .bus_rdy     (bus_rdy),
    .irq         (irq),
    .irq_id      (irq_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus_req = 1'b1; bus_rw = 1'b1; bus_addr = a; bus_wr_data = d;
    tick();
    bus_req = 1'b0; bus_rw = 1'b0; bus_wr_data = '0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bus_req = 1'b1; bus_rw = 1'b0; bus_addr = a;
    tick();
    d = bus_rd_data;
    check("rd_rdy", 32'(bus_rdy), 32'd1);
    bus_req = 1'b0;
  endtask

  initial begin
    reset = 1'b1; src_irq = '0; bus_req = 1'b0; bus_rw = 1'b0;
    bus_addr = '0; bus_wr_data = '0;
    ticks(3);
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_irq_id", 32'(irq_id), 32'h0);
    check("rst_rdy", 32'(bus_rdy), 32'h0);
    check("rst_rd_data", bus_rd_data, 32'h0);
    reset = 1'b0;

    bus_read(3'd0, rdv); check("rst_pend", rdv, 32'h0);
    tick();
    check("rdy_one_cycle", 32'(bus_rdy), 32'h0);
    bus_read(3'd1, rdv); check("rst_en", rdv, 32'h0);
    bus_read(3'd2, rdv); check("rst_mode", rdv, 32'h0);
    bus_read(3'd3, rdv); check("rst_active", rdv, 32'h0);

    // Level line 3, latency SYNC_STAGES+2
    bus_write(3'd1, 32'hFFFF_FFFF);
    bus_read(3'd1, rdv); check("en_upper_ignored", rdv, 32'hFF);
    src_irq = 8'h08;
    ticks(3);
    check("lvl3_not_yet", 32'(irq), 32'h0);
    tick();
    check("lvl3_irq", 32'(irq), 32'h08);
    check("lvl3_id", 32'(irq_id), 32'd3);

    // Reset while in REQ, with a read strobe that reset must suppress
    reset = 1'b1; bus_req = 1'b1; src_irq = '0;
    tick();
    check("midreq_irq", 32'(irq), 32'h0);
    check("midreq_id", 32'(irq_id), 32'h0);
    check("midreq_rdy", 32'(bus_rdy), 32'h0);
    reset = 1'b0; bus_req = 1'b0;
    bus_read(3'd0, rdv); check("midreq_pend", rdv, 32'h0);
    bus_read(3'd1, rdv); check("midreq_en", rdv, 32'h0);
    bus_read(3'd3, rdv); check("midreq_active", rdv, 32'h0);

    // Edge mode: lines 5 and 2 rise together, 2 wins
    bus_write(3'd1, 32'hFF);
    bus_write(3'd2, 32'hFF);
    src_irq = 8'h24;
    ticks(4);
    check("edge_irq2", 32'(irq), 32'h04);
    check("edge_id2", 32'(irq_id), 32'd2);
    bus_read(3'd0, rdv); check("edge_pend", rdv, 32'h24);
    bus_read(3'd3, rdv); check("active_req2", rdv, 32'h0A);
    src_irq = 8'h25;
    ticks(5);
    check("no_nesting", 32'(irq), 32'h04);
    bus_write(3'd1, 32'hFB);
    check("en_clear_holds", 32'(irq), 32'h04);
    bus_write(3'd1, 32'hFF);
    bus_write(3'd0, 32'h05);
    bus_read(3'd0, rdv); check("w1c_pend", rdv, 32'h20);
    bus_write(3'd4, 32'h0);
    check("eoi_low", 32'(irq), 32'h0);
    tick();
    check("next_irq5", 32'(irq), 32'h20);
    check("next_id5", 32'(irq_id), 32'd5);
    bus_write(3'd0, 32'h20);
    check("pend_clear_holds", 32'(irq), 32'h20);
    bus_write(3'd4, 32'h0);
    check("eoi2_low", 32'(irq), 32'h0);
    ticks(2);
    check("idle_stays_low", 32'(irq), 32'h0);
    bus_write(3'd4, 32'h0);
    check("eoi_idle_irq", 32'(irq), 32'h0);
    bus_read(3'd3, rdv); check("active_idle", rdv, 32'h05);

    // Edge line 4: held after source falls, set beats W1C in the same cycle
    bus_write(3'd1, 32'h00);
    src_irq = src_irq | 8'h10;
    ticks(4);
    bus_read(3'd0, rdv); check("edge4_pend", rdv, 32'h10);
    src_irq = src_irq & 8'hEF;
    ticks(3);
    bus_read(3'd0, rdv); check("edge4_held", rdv, 32'h10);
    src_irq = src_irq | 8'h10;
    ticks(2);
    bus_write(3'd0, 32'h10);
    bus_read(3'd0, rdv); check("set_beats_clear", rdv, 32'h10);
    bus_write(3'd0, 32'h10);
    bus_read(3'd0, rdv); check("w1c_only", rdv, 32'h00);

    // Level mode: pend tracks the synced sources
    bus_write(3'd2, 32'h00);
    tick();
    bus_read(3'd0, rdv); check("lvl_pend", rdv, 32'h35);
    src_irq = '0;
    ticks(4);
    bus_read(3'd0, rdv); check("lvl_pend_drop", rdv, 32'h00);
    bus_read(3'd7, rdv); check("addr7_zero", rdv, 32'h0);

`ifdef IRQC_TIMER_EN
    bus_write(3'd1, 32'h80);
    bus_write(3'd6, 32'd20);
    bus_write(3'd5, 32'd0);
    ticks(21);
    check("timer_not_yet", 32'(irq), 32'h0);
    tick();
    check("timer_irq", 32'(irq), 32'h80);
    check("timer_id", 32'(irq_id), 32'd7);
    bus_write(3'd0, 32'h80);
    bus_write(3'd4, 32'h0);
    bus_write(3'd6, 32'd0);
    bus_write(3'd5, 32'd0);
    ticks(30);
    check("timer_off_irq", 32'(irq), 32'h0);
    bus_read(3'd0, rdv); check("timer_off_pend", rdv, 32'h0);
    bus_write(3'd5, 32'd100);
    bus_read(3'd5, rdv); check("tcount_load", rdv, 32'd100);
`else
    bus_write(3'd5, 32'h1234);
    bus_read(3'd5, rdv); check("addr5_zero", rdv, 32'h0);
    bus_write(3'd6, 32'h1234);
    bus_read(3'd6, rdv); check("addr6_zero", rdv, 32'h0);
    bus_write(3'd1, 32'h80);
    src_irq = 8'h80;
    ticks(4);
    check("line7_irq", 32'(irq), 32'h80);
    check("line7_id", 32'(irq_id), 32'd7);
    src_irq = '0;
    bus_write(3'd4, 32'h0);
    check("line7_eoi", 32'(irq), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
